// File: rtl/sprite_line_renderer.sv
// Per-line sprite compositor: a fill FSM writes up to NUM_SPRITES ROM rows into the
// back line buffer while the front buffer streams to the colour mapper, clearing as it reads.
module sprite_line_renderer #(
  parameter int NUM_SPRITES = 4,
  parameter int SPR_W       = 32,
  parameter int SPR_H       = 32,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480
) (
  input  logic                                                        Clk,
  input  logic                                                        Reset,
  input  logic [9:0]                                                  DrawX,
  input  logic                                                        line_start,
  input  logic [9:0]                                                  next_line,
  input  logic [NUM_SPRITES-1:0]                                      spr_en,
  input  logic [10*NUM_SPRITES-1:0]                                   spr_x,
  input  logic [10*NUM_SPRITES-1:0]                                   spr_y,
  output logic [$clog2(NUM_SPRITES)+$clog2(SPR_H)+$clog2(SPR_W)-1:0] rom_addr,
  input  logic [3:0]                                                  rom_data,
  output logic [3:0]                                                  sprite_data,
  output logic                                                        busy,
  output logic                                                        overrun
);

  localparam int SW = $clog2(NUM_SPRITES);
  localparam int RW = $clog2(SPR_H);
  localparam int CW = $clog2(SPR_W);
  localparam logic [10:0] H_LIM = 11'(H_ACTIVE);
  localparam logic [10:0] V_LIM = 11'(V_ACTIVE);
  localparam logic [10:0] H_SPR = 11'(SPR_H);

  typedef enum logic [1:0] {IDLE, CHECK, FETCH, DRAIN} state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [9:0]    line_q, line_d;
  logic          pend_v_q, pend_v_d;
  logic [CW-1:0] pend_col_q, pend_col_d;

  logic          sel_q;
  logic          blank_q;
  logic          overrun_q;
  logic [9:0]    drawx_q;
  logic [3:0]    pix_q;

  logic [3:0]    buf0 [H_ACTIVE];
  logic [3:0]    buf1 [H_ACTIVE];

  logic [10:0]   line11, cur_x, cur_y, row_full, wr_x;
  logic          hit, wr_en, clr_en, rd_in;
  logic [9:0]    rd_idx;
  logic [3:0]    front_val;

  assign line11   = {1'b0, line_q};
  assign cur_x    = {1'b0, spr_x[10*int'(slot_q) +: 10]};
  assign cur_y    = {1'b0, spr_y[10*int'(slot_q) +: 10]};
  assign row_full = line11 - cur_y;
  assign hit      = spr_en[slot_q] && (line11 < V_LIM) &&
                    (cur_y <= line11) && (line11 < cur_y + H_SPR);

  // Data for column pend_col_q arrives one Clk after its address was issued.
  assign wr_x  = cur_x + 11'(pend_col_q);
  assign wr_en = pend_v_q && (rom_data != 4'd0) && (wr_x < H_LIM);

  assign rd_in  = {1'b0, DrawX} < H_LIM;
  assign rd_idx = rd_in ? DrawX : '0;
  assign clr_en = (DrawX != drawx_q) && ({1'b0, drawx_q} < H_LIM);

  always_comb begin
    front_val = sel_q ? buf1[rd_idx] : buf0[rd_idx];
  end

  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    row_d      = row_q;
    col_d      = col_q;
    line_d     = line_q;
    pend_v_d   = 1'b0;
    pend_col_d = pend_col_q;
    if (line_start) begin
      state_d = CHECK;
      slot_d  = '1;
      line_d  = next_line;
    end else begin
      case (state_q)
        IDLE: ;
        CHECK: begin
          if (hit) begin
            row_d   = row_full[RW-1:0];
            col_d   = '0;
            state_d = FETCH;
          end else if (slot_q == '0) begin
            state_d = IDLE;
          end else begin
            slot_d = slot_q - 1'b1;
          end
        end
        FETCH: begin
          pend_v_d   = 1'b1;
          pend_col_d = col_q;
          col_d      = col_q + 1'b1;
          if (col_q == '1) state_d = DRAIN;
        end
        DRAIN: begin
          if (slot_q == '0) begin
            state_d = IDLE;
          end else begin
            slot_d  = slot_q - 1'b1;
            state_d = CHECK;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      slot_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      line_q     <= '0;
      pend_v_q   <= 1'b0;
      pend_col_q <= '0;
      sel_q      <= 1'b0;
      blank_q    <= 1'b1;
      overrun_q  <= 1'b0;
      drawx_q    <= '1;
      pix_q      <= '0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      row_q      <= row_d;
      col_q      <= col_d;
      line_q     <= line_d;
      pend_v_q   <= pend_v_d;
      pend_col_q <= pend_col_d;
      drawx_q    <= DrawX;
      pix_q      <= (blank_q || !rd_in) ? 4'd0 : front_val;
      if (line_start) begin
        sel_q   <= ~sel_q;
        blank_q <= 1'b0;
        if (state_q != IDLE) overrun_q <= 1'b1;
      end
    end
  end

  // Front and back never alias, so each buffer sees at most one write per Clk.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      if (sel_q) begin
        if (clr_en) buf1[drawx_q] <= '0;
        if (wr_en)  buf0[wr_x[9:0]] <= rom_data;
      end else begin
        if (clr_en) buf0[drawx_q] <= '0;
        if (wr_en)  buf1[wr_x[9:0]] <= rom_data;
      end
    end
  end

  assign rom_addr    = {slot_q, row_q, col_q};
  assign sprite_data = pix_q;
  assign busy        = (state_q != IDLE);
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_sprite_line_renderer.sv
// Bench for sprite_line_renderer: a line-image model built from sprite geometry and the
// bench ROM, checked pixel-by-pixel on every Clk, plus fill timing and rom_addr sequencing.
module tb_sprite_line_renderer;

  localparam int NS = 4;
  localparam int SW = 32;
  localparam int SH = 32;
  localparam int HA = 640;
  localparam int VA = 480;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [9:0]  DrawX;
  logic        line_start;
  logic [9:0]  next_line;
  logic [3:0]  spr_en;
  logic [39:0] spr_x;
  logic [39:0] spr_y;
  logic [11:0] rom_addr;
  logic [3:0]  rom_data;
  logic [3:0]  sprite_data;
  logic        busy;
  logic        overrun;

  logic [3:0]  rom [4096];
  logic [3:0]  disp [HA];
  logic [3:0]  pend [HA];
  logic [3:0]  nxt [HA];
  bit          blank_m;
  bit          chk_pix;
  int          exp_tl[$];
  int          n_checks = 0;
  int          n_fail = 0;

  always #10 Clk = ~Clk;

  sprite_line_renderer #(
    .NUM_SPRITES(NS), .SPR_W(SW), .SPR_H(SH), .H_ACTIVE(HA), .V_ACTIVE(VA)
  ) dut (
    .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .line_start(line_start),
    .next_line(next_line), .spr_en(spr_en), .spr_x(spr_x), .spr_y(spr_y),
    .rom_addr(rom_addr), .rom_data(rom_data), .sprite_data(sprite_data),
    .busy(busy), .overrun(overrun)
  );

  always @(posedge Clk) rom_data <= rom[rom_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic int sx(input int s);
    return int'(spr_x[10*s +: 10]);
  endfunction

  function automatic int sy(input int s);
    return int'(spr_y[10*s +: 10]);
  endfunction

  function automatic bit hit_m(input int s, input int L);
    return spr_en[s] && (L < VA) && (sy(s) <= L) && (L < sy(s) + SH);
  endfunction

  // Line image: the lowest-numbered slot with an opaque pixel at x wins.
  task automatic build_img(input int L);
    for (int x = 0; x < HA; x++) begin
      logic [3:0] v;
      v = 4'd0;
      for (int s = 0; s < NS; s++) begin
        if (v == 4'd0 && hit_m(s, L)) begin
          int c;
          c = x - sx(s);
          if (c >= 0 && c < SW) v = rom[s*1024 + (L - sy(s))*32 + c];
        end
      end
      nxt[x] = v;
    end
  endtask

  // Each slot costs one probe Clk; a hit adds SW fetch cycles and one drain cycle.
  task automatic build_timeline(input int L);
    exp_tl.delete();
    for (int s = NS-1; s >= 0; s--) begin
      exp_tl.push_back(-1);
      if (hit_m(s, L)) begin
        for (int c = 0; c < SW; c++) exp_tl.push_back(s*1024 + (L - sy(s))*32 + c);
        exp_tl.push_back(-1);
      end
    end
  endtask

  // Pixel compare process; also owns the display-side model state.
  logic [3:0] exp_pix;
  bit         exp_v = 0;
  int         prev_x = 1023;
  int         cur_x;
  always @(negedge Clk) begin
    if (Reset) begin
      exp_v   = 0;
      prev_x  = 1023;
      blank_m = 1;
    end else begin
      if (exp_v && chk_pix) check("pixel", sprite_data, exp_pix);
      cur_x   = int'(DrawX);
      exp_pix = (blank_m || cur_x >= HA) ? 4'd0 : disp[cur_x];
      exp_v   = 1;
      if (cur_x != prev_x && prev_x < HA) disp[prev_x] = 4'd0;
      prev_x = cur_x;
      if (line_start) begin
        for (int i = 0; i < HA; i++) begin
          disp[i] = pend[i];
          pend[i] = nxt[i];
        end
        blank_m = 0;
      end
    end
  end

  task automatic do_swap(input int L, input bit wait_done);
    int i;
    build_timeline(L);
    build_img(L);
    next_line  = 10'(L);
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    check("busy_on_swap", busy, 1);
    check("slot_on_swap", rom_addr[11:10], NS-1);
    if (wait_done) begin
      i = 0;
      while (busy === 1'b1 && i < 600) begin
        if (i < exp_tl.size() && exp_tl[i] >= 0) check("rom_addr", rom_addr, exp_tl[i]);
        i++;
        tick();
      end
      check("busy_cycles", i, exp_tl.size());
    end
  endtask

  task automatic scan(input int hold);
    for (int x = 0; x < HA; x++) begin
      for (int h = 0; h < hold; h++) begin
        DrawX = 10'(x);
        tick();
      end
    end
    DrawX = 10'd700;
    repeat (3) tick();
  endtask

  task automatic set_slot(input int s, input bit e, input int x, input int y);
    spr_en[s]       = e;
    spr_x[10*s +: 10] = 10'(x);
    spr_y[10*s +: 10] = 10'(y);
  endtask

  task automatic fill_slot(input int s, input logic [3:0] v);
    for (int i = 0; i < 1024; i++) rom[s*1024 + i] = v;
  endtask

  // Two blank-initialised passes so both line buffers are known clear.
  task automatic warmup();
    chk_pix = 1;
    scan(1);
    do_swap(10, 1);
    chk_pix = 0;
    scan(1);
    do_swap(1000, 1);
    chk_pix = 1;
  endtask

  initial begin
    Reset = 1'b1; line_start = 1'b0; next_line = '0; DrawX = 10'd800;
    spr_en = '0; spr_x = '0; spr_y = '0; chk_pix = 0; blank_m = 1;
    for (int i = 0; i < 4096; i++) rom[i] = 4'd0;
    for (int i = 0; i < HA; i++) begin disp[i] = 0; pend[i] = 0; nxt[i] = 0; end
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_sprite_data", sprite_data, 0);
    check("rst_rom_addr", rom_addr, 0);
    Reset = 1'b0;

    warmup();
    scan(1);

    fill_slot(0, 4'd5);
    set_slot(0, 1, 100, 50);
    do_swap(60, 1);
    check("pin_row_addr", exp_tl[4], 320);
    check("pin_img100", nxt[100], 5);
    check("pin_img131", nxt[131], 5);
    check("pin_img99", nxt[99], 0);
    check("pin_img132", nxt[132], 0);
    do_swap(1000, 1);
    scan(1);

    fill_slot(0, 4'd3);
    fill_slot(1, 4'd7);
    set_slot(0, 1, 100, 0);
    set_slot(1, 1, 100, 0);
    do_swap(0, 1);
    check("pin_ovl100", nxt[100], 3);
    check("pin_ovl131", nxt[131], 3);
    do_swap(1000, 1);
    scan(1);

    set_slot(1, 0, 0, 0);
    fill_slot(0, 4'd2);
    set_slot(0, 1, 620, 0);
    do_swap(0, 1);
    check("pin_edge620", nxt[620], 2);
    check("pin_edge639", nxt[639], 2);
    check("pin_edge0", nxt[0], 0);
    do_swap(1000, 1);
    scan(2);

    set_slot(0, 1, 300, 0);
    do_swap(5, 1);
    do_swap(1000, 1);
    scan(2);
    do_swap(1000, 1);
    scan(2);
    scan(1);

    for (int it = 0; it < 12; it++) begin
      int L;
      for (int i = 0; i < 4096; i++)
        rom[i] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      L = ($urandom_range(0, 9) == 0) ? int'($urandom_range(470, 520)) : int'($urandom_range(0, 479));
      for (int s = 0; s < NS; s++) begin
        int y, x;
        y = L - int'($urandom_range(0, 40));
        if (y < 0) y = 0;
        if ($urandom_range(0, 4) == 0) y = int'($urandom_range(0, 1023));
        x = ($urandom_range(0, 3) == 0) ? int'($urandom_range(600, 660)) : int'($urandom_range(0, 700));
        set_slot(s, ($urandom_range(0, 3) != 0), x, y);
      end
      do_swap(L, 1);
      scan(int'($urandom_range(1, 2)));
    end
    do_swap(1000, 1);
    scan(1);

    for (int s = 0; s < NS; s++) begin
      fill_slot(s, 4'(s + 1));
      set_slot(s, 1, 150*s, 200);
    end
    check("overrun_before", overrun, 0);
    do_swap(210, 0);
    repeat (19) tick();
    chk_pix = 0;
    do_swap(210, 1);
    check("overrun_set", overrun, 1);
    repeat (50) tick();
    check("overrun_sticky", overrun, 1);
    do_swap(1000, 1);
    check("overrun_sticky2", overrun, 1);

    Reset = 1'b1;
    line_start = 1'b1;
    next_line = 10'd210;
    tick();
    line_start = 1'b0;
    check("rst_win_busy", busy, 0);
    check("rst_win_overrun", overrun, 0);
    check("rst_win_pix", sprite_data, 0);
    tick();
    Reset = 1'b0;

    warmup();
    do_swap(205, 1);
    do_swap(1000, 1);
    scan(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
